// File: rtl/uart_reg_responder_if.sv
// Byte-stream and register-bus signals between the UART, the register
// responder and the register bank.
interface uart_reg_responder_if;
  logic [7:0] rxdata;
  logic       rx_enable;
  logic [7:0] txdata;
  logic       tx_enable;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;

  // master: the UART receiver and register bank that surround the responder
  modport master (
    output rxdata, rx_enable, reg_rdata,
    input  txdata, tx_enable, reg_addr, reg_wdata, reg_wr, reg_rd, busy
  );

  modport slave (
    input  rxdata, rx_enable, reg_rdata,
    output txdata, tx_enable, reg_addr, reg_wdata, reg_wr, reg_rd, busy
  );
endinterface

// File: rtl/uart_reg_responder.sv
// Decodes 'W' addr data / 'R' addr commands from UART bytes, drives the register
// bus and returns one response byte. Optional inter-byte timeout: UART_RESP_TIMEOUT_EN.
module uart_reg_responder #(
  parameter int CLK32_FREQ = 32_000_000,
  parameter int BAUD_FREQ  = 115_200,
  parameter int TX_GAP     = (CLK32_FREQ / BAUD_FREQ) * 11,
  parameter int NUM_REGS   = 16,
  parameter int TIMEOUT    = (CLK32_FREQ / BAUD_FREQ) * 40
) (
  input  logic                 clk32,
  input  logic                 reset_,
  uart_reg_responder_if.slave  bus
);
  localparam int GAP_W = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, BUS, RD_WAIT, SEND, GAP
  } state_t;

  state_t           state_reg, state_next;
  logic             rx_en_q_reg;
  logic             is_wr_reg, is_wr_next;
  logic [7:0]       addr_reg, addr_next;
  logic [7:0]       wdata_reg, wdata_next;
  logic [7:0]       resp_reg, resp_next;
  logic [GAP_W-1:0] gap_ctr_reg, gap_ctr_next;
  logic             byte_evt;
  logic             addr_ok;
  logic             wr_strobe, rd_strobe, tx_pulse;

  assign byte_evt = bus.rx_enable & ~rx_en_q_reg;
  assign addr_ok  = ({1'b0, addr_reg} < 9'(NUM_REGS));

`ifdef UART_RESP_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0] to_ctr_reg, to_ctr_next;
  logic            to_expired;

  assign to_expired = (to_ctr_reg == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk32 or negedge reset_) begin
    if (!reset_) to_ctr_reg <= '0;
    else         to_ctr_reg <= to_ctr_next;
  end
`endif

  always_ff @(posedge clk32 or negedge reset_) begin
    if (!reset_) begin
      state_reg   <= IDLE;
      rx_en_q_reg <= 1'b0;
      is_wr_reg   <= 1'b0;
      addr_reg    <= 8'h00;
      wdata_reg   <= 8'h00;
      resp_reg    <= 8'h00;
      gap_ctr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rx_en_q_reg <= bus.rx_enable;
      is_wr_reg   <= is_wr_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      resp_reg    <= resp_next;
      gap_ctr_reg <= gap_ctr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    is_wr_next   = is_wr_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    resp_next    = resp_reg;
    gap_ctr_next = gap_ctr_reg;
    wr_strobe    = 1'b0;
    rd_strobe    = 1'b0;
    tx_pulse     = 1'b0;
`ifdef UART_RESP_TIMEOUT_EN
    to_ctr_next  = '0;
`endif
    unique case (state_reg)
      IDLE: begin
        if (byte_evt) begin
          if (bus.rxdata == CMD_WR || bus.rxdata == CMD_RD) begin
            is_wr_next = (bus.rxdata == CMD_WR);
            state_next = GET_ADDR;
          end else begin
            resp_next  = NAK;
            state_next = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (byte_evt) begin
          addr_next  = bus.rxdata;
          state_next = is_wr_reg ? GET_DATA : BUS;
        end
`ifdef UART_RESP_TIMEOUT_EN
        else if (to_expired) state_next = IDLE;
        else to_ctr_next = to_ctr_reg + 1'b1;
`endif
      end
      GET_DATA: begin
        if (byte_evt) begin
          wdata_next = bus.rxdata;
          state_next = BUS;
        end
`ifdef UART_RESP_TIMEOUT_EN
        else if (to_expired) state_next = IDLE;
        else to_ctr_next = to_ctr_reg + 1'b1;
`endif
      end
      BUS: begin
        // Out-of-range addresses still consume the whole command but never strobe
        if (!addr_ok) begin
          resp_next  = NAK;
          state_next = SEND;
        end else if (is_wr_reg) begin
          wr_strobe  = 1'b1;
          resp_next  = ACK;
          state_next = SEND;
        end else begin
          rd_strobe  = 1'b1;
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        resp_next  = bus.reg_rdata;
        state_next = SEND;
      end
      SEND: begin
        tx_pulse     = 1'b1;
        gap_ctr_next = GAP_W'(TX_GAP - 1);
        state_next   = (TX_GAP > 1) ? GAP : IDLE;
      end
      GAP: begin
        // Leaving as the counter reaches zero makes busy fall TX_GAP cycles after tx_enable
        gap_ctr_next = gap_ctr_reg - 1'b1;
        if (gap_ctr_reg <= GAP_W'(1)) begin
          gap_ctr_next = '0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.txdata    = resp_reg;
  assign bus.tx_enable = tx_pulse;
  assign bus.reg_addr  = addr_reg;
  assign bus.reg_wdata = wdata_reg;
  assign bus.reg_wr    = wr_strobe;
  assign bus.reg_rd    = rd_strobe;
  assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench for uart_reg_responder: stimulus queues expected strobes and
// response bytes, a negedge monitor pops and compares them.
module tb_uart_reg_responder;
  localparam int TX_GAP   = 20;
  localparam int TIMEOUT  = 30;
  localparam int NUM_REGS = 16;

  logic clk32  = 1'b0;
  logic reset_ = 1'b0;
  always #5 clk32 = ~clk32;

  uart_reg_responder_if bus();

  uart_reg_responder #(
    .TX_GAP   (TX_GAP),
    .NUM_REGS (NUM_REGS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk32  (clk32),
    .reset_ (reset_),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0] data;
    int         lat;
  } tx_exp_t;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         lat;
  } bus_exp_t;

  tx_exp_t    tx_q[$];
  bus_exp_t   bus_q[$];
  tx_exp_t    te;
  bus_exp_t   be;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_drive_cyc = 0;
  int         last_tx_cyc = 0;
  int         tx_count = 0;
  logic [7:0] bank [16];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Register bank: initial contents 0x30+addr, read data valid the cycle after reg_rd
  always @(posedge clk32 or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < 16; i++) bank[i] <= 8'h30 + 8'(i);
      bus.reg_rdata <= 8'h00;
    end else begin
      if (bus.reg_wr) bank[bus.reg_addr[3:0]] <= bus.reg_wdata;
      if (bus.reg_rd) bus.reg_rdata <= bank[bus.reg_addr[3:0]];
    end
  end

  always @(posedge clk32) cyc <= cyc + 1;

  // Monitor: every tx_enable and every bus strobe must match the head of its queue
  always @(negedge clk32) begin
    if (bus.reg_wr && bus.reg_rd) check("wr_rd_exclusive", 1, 0);
    if (bus.tx_enable) begin
      tx_count++;
      last_tx_cyc = cyc;
      if (tx_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected: got tx_enable with txdata %02h, required none", bus.txdata);
      end else begin
        te = tx_q.pop_front();
        check("txdata", int'(bus.txdata), int'(te.data));
        check("tx_latency", cyc - last_drive_cyc, te.lat);
      end
    end
    if (bus.reg_wr || bus.reg_rd) begin
      if (bus_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL strobe_unexpected: got wr=%0b rd=%0b addr %02h, required none",
                 bus.reg_wr, bus.reg_rd, bus.reg_addr);
      end else begin
        be = bus_q.pop_front();
        check("strobe_is_wr", int'(bus.reg_wr), int'(be.wr));
        check("reg_addr", int'(bus.reg_addr), int'(be.addr));
        if (be.wr) check("reg_wdata", int'(bus.reg_wdata), int'(be.wdata));
        check("strobe_latency", cyc - last_drive_cyc, be.lat);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk32);
    bus.rxdata     = b;
    bus.rx_enable  = 1'b1;
    last_drive_cyc = cyc;
    repeat (hold) @(negedge clk32);
    bus.rx_enable  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300 && bus.busy; i++) @(negedge clk32);
    check(name, int'(bus.busy), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_txdata"}, int'(bus.txdata), 0);
    check({tag, "_tx_enable"}, int'(bus.tx_enable), 0);
    check({tag, "_reg_addr"}, int'(bus.reg_addr), 0);
    check({tag, "_reg_wdata"}, int'(bus.reg_wdata), 0);
    check({tag, "_strobes"}, int'({bus.reg_wr, bus.reg_rd}), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  int k;
  int n_tx;

  initial begin
    bus.rxdata    = 8'h00;
    bus.rx_enable = 1'b0;
    repeat (3) @(negedge clk32);
    check_outputs_zero("reset");
    reset_ = 1'b1;
    repeat (2) @(negedge clk32);

    // Write 0xA5 to reg 3, bytes held as levels for 3 cycles
    bus_q.push_back('{wr: 1'b1, addr: 8'h03, wdata: 8'hA5, lat: 1});
    tx_q.push_back('{data: 8'h06, lat: 2});
    send_byte(8'h57, 3);
    send_byte(8'h03, 3);
    send_byte(8'hA5, 3);
    wait_idle("write_idle");

    // Read reg 3 back
    bus_q.push_back('{wr: 1'b0, addr: 8'h03, wdata: 8'h00, lat: 1});
    tx_q.push_back('{data: 8'hA5, lat: 3});
    send_byte(8'h52, 1);
    send_byte(8'h03, 1);
    wait_idle("read_idle");

    // Unknown command
    tx_q.push_back('{data: 8'h15, lat: 1});
    send_byte(8'h41, 1);
    wait_idle("badcmd_idle");

    // Write to address NUM_REGS: consumed, no strobe, NAK
    tx_q.push_back('{data: 8'h15, lat: 2});
    send_byte(8'h57, 1);
    send_byte(8'h10, 1);
    send_byte(8'h00, 1);
    wait_idle("badaddr_idle");

    // Read reg 0, then a second command byte during GAP that must be dropped
    bus_q.push_back('{wr: 1'b0, addr: 8'h00, wdata: 8'h00, lat: 1});
    tx_q.push_back('{data: 8'h30, lat: 3});
    n_tx = tx_count;
    send_byte(8'h52, 1);
    send_byte(8'h00, 1);
    for (int i = 0; i < 50 && tx_count == n_tx; i++) @(negedge clk32);
    check("pace_tx_seen", tx_count - n_tx, 1);
    repeat (3) @(negedge clk32);
    send_byte(8'h52, 1);
    for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk32);
    check("pace_busy_fall", cyc - last_tx_cyc, TX_GAP);
    check("pace_txdata_held", int'(bus.txdata), 8'h30);
    repeat (5) @(negedge clk32);
    check("pace_busy_stays_low", int'(bus.busy), 0);
    check("pace_single_tx", tx_count - n_tx, 1);

    // Must still be at command level after the dropped byte
    tx_q.push_back('{data: 8'h15, lat: 1});
    send_byte(8'h41, 1);
    wait_idle("post_drop_idle");

    // Reset in the middle of a write command
    send_byte(8'h57, 1);
    send_byte(8'h05, 1);
    @(negedge clk32);
    reset_ = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (2) @(negedge clk32);
    check_outputs_zero("midrst_hold");
    reset_ = 1'b1;
    repeat (3) @(negedge clk32);
    tx_q.push_back('{data: 8'h15, lat: 1});
    send_byte(8'h99, 1);
    wait_idle("postrst_idle");

`ifdef UART_RESP_TIMEOUT_EN
    // Lone 'W' then silence: returns to IDLE without strobe or response
    send_byte(8'h57, 1);
    k = last_drive_cyc;
    for (int i = 0; i < 200 && bus.busy; i++) @(negedge clk32);
    check("timeout_busy_fall", cyc - k, TIMEOUT + 1);
    bus_q.push_back('{wr: 1'b0, addr: 8'h01, wdata: 8'h00, lat: 1});
    tx_q.push_back('{data: 8'h31, lat: 3});
    send_byte(8'h52, 1);
    send_byte(8'h01, 1);
    wait_idle("timeout_read_idle");
`endif

    repeat (5) @(negedge clk32);
    check("tx_queue_drained", tx_q.size(), 0);
    check("bus_queue_drained", bus_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
